// File: rtl/sys_mem_arbiter_if.sv
// Bus bundle for the system memory arbiter: requester ports, testbench
// control port, RAM port, halt inputs and status outputs.
interface sys_mem_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int GIDW = (NREQ > 2) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]    req_ren;
    logic [NREQ-1:0]    req_wen;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_store;
    logic [NREQ-1:0]    req_wait;
    logic [DW-1:0]      req_load;

    logic               tb_ctrl;
    logic               tb_ren;
    logic               tb_wen;
    logic [AW-1:0]      tb_addr;
    logic [DW-1:0]      tb_store;
    logic               tb_owns;

    logic               ram_ren;
    logic               ram_wen;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_store;
    logic [DW-1:0]      ram_load;
    logic               ram_ready;

    logic [NREQ-1:0]    cpu_halt;
    logic               halt;
    logic               cpuclk_en;
    logic [GIDW-1:0]    grant_id;

    // Arbiter side
    modport slave (
        input  req_ren, req_wen, req_addr, req_store,
        output req_wait, req_load,
        input  tb_ctrl, tb_ren, tb_wen, tb_addr, tb_store,
        output tb_owns,
        output ram_ren, ram_wen, ram_addr, ram_store,
        input  ram_load, ram_ready,
        input  cpu_halt,
        output halt, cpuclk_en, grant_id
    );

    // Requesters / testbench / RAM side
    modport master (
        output req_ren, req_wen, req_addr, req_store,
        input  req_wait, req_load,
        output tb_ctrl, tb_ren, tb_wen, tb_addr, tb_store,
        input  tb_owns,
        input  ram_ren, ram_wen, ram_addr, ram_store,
        output ram_load, ram_ready,
        output cpu_halt,
        input  halt, cpuclk_en, grant_id
    );
endinterface

// File: rtl/sys_mem_arbiter.sv
// N-way memory front end: round-robin arbitration of processor requesters
// onto a single-ported RAM, testbench takeover that waits for the current
// access to drain, free-running CPU clock-enable divider and sticky
// all-core halt detection.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | RAM idle; pick next requester round-robin or hand RAM to tb
//   BUSY  | granted requester drives RAM until ram_ready or it withdraws
//   TB    | testbench drives RAM until tb_ctrl drops
module sys_mem_arbiter #(
    parameter int NREQ   = 2,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int CLKDIV = 2,
    parameter int GIDW   = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    sys_mem_arbiter_if.slave  bus
);
    localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_TB   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [GIDW-1:0] grant_id_q, grant_id_d;
    logic [GIDW-1:0] last_grant_q, last_grant_d;
    logic [CW-1:0]   div_cnt_q, div_cnt_d;
    logic [NREQ-1:0] halt_seen_q, halt_seen_d;
    logic            halt_q, halt_d;

    logic [NREQ-1:0] req_any;
    logic [GIDW-1:0] rr_pick;
    logic            rr_valid;
    logic [GIDW:0]   rr_cand;
    logic            div_wrap;

    logic            g_ren, g_wen;
    logic [AW-1:0]   g_addr;
    logic [DW-1:0]   g_store;

    assign req_any = bus.req_ren | bus.req_wen;
    assign g_ren   = bus.req_ren[grant_id_q];
    assign g_wen   = bus.req_wen[grant_id_q];
    assign g_addr  = bus.req_addr[int'(grant_id_q)*AW +: AW];
    assign g_store = bus.req_store[int'(grant_id_q)*DW +: DW];

    // Round-robin search: first requester after last_grant, wrapping at NREQ
    always_comb begin
        rr_pick  = '0;
        rr_valid = 1'b0;
        rr_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_cand = {1'b0, last_grant_q} + (GIDW+1)'(k);
            if (rr_cand >= (GIDW+1)'(NREQ)) begin
                rr_cand = rr_cand - (GIDW+1)'(NREQ);
            end
            if (!rr_valid && req_any[rr_cand[GIDW-1:0]]) begin
                rr_valid = 1'b1;
                rr_pick  = rr_cand[GIDW-1:0];
            end
        end
    end

    // Next-state and RAM port mux; enables stay low when nobody owns the RAM
    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        bus.ram_ren   = 1'b0;
        bus.ram_wen   = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_store = '0;
        bus.tb_owns   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.tb_ctrl) begin
                    state_d = S_TB;
                end else if (rr_valid) begin
                    grant_id_d = rr_pick;
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                bus.ram_addr  = g_addr;
                bus.ram_store = g_store;
                if (!g_ren && !g_wen) begin
                    // Grantee withdrew: abandon without crediting its turn
                    state_d = S_IDLE;
                end else begin
                    bus.ram_wen = g_wen;
                    bus.ram_ren = g_ren & ~g_wen;
                    if (bus.ram_ready) begin
                        last_grant_d = grant_id_q;
                        state_d      = bus.tb_ctrl ? S_TB : S_IDLE;
                    end
                end
            end
            S_TB: begin
                bus.tb_owns   = 1'b1;
                bus.ram_addr  = bus.tb_addr;
                bus.ram_store = bus.tb_store;
                bus.ram_wen   = bus.tb_wen;
                bus.ram_ren   = bus.tb_ren & ~bus.tb_wen;
                if (!bus.tb_ctrl) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stall every active requester except the grantee in its completion cycle
    always_comb begin
        bus.req_wait = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_wait[i] = req_any[i] &
                ~((state_q == S_BUSY) && (grant_id_q == GIDW'(i)) && bus.ram_ready);
        end
    end

    // Divider counter and halt accumulation next-state
    always_comb begin
        div_wrap    = (div_cnt_q == CW'(CLKDIV - 1));
        div_cnt_d   = div_wrap ? '0 : div_cnt_q + 1'b1;
        halt_seen_d = halt_seen_q | bus.cpu_halt;
        halt_d      = &halt_seen_d;
    end

    assign bus.req_load  = bus.ram_load;
    assign bus.cpuclk_en = div_wrap;
    assign bus.halt      = halt_q;
    assign bus.grant_id  = grant_id_q;

    // State registers; last_grant resets to NREQ-1 so requester 0 wins first
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            grant_id_q   <= '0;
            last_grant_q <= GIDW'(NREQ - 1);
            div_cnt_q    <= '0;
            halt_seen_q  <= '0;
            halt_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            div_cnt_q    <= div_cnt_d;
            halt_seen_q  <= halt_seen_d;
            halt_q       <= halt_d;
        end
    end
endmodule

// File: tb/tb_sys_mem_arbiter.sv
// Directed bench for sys_mem_arbiter: vector table for arbitration and
// takeover on a 2-requester instance, hand sequences for long transactions,
// reset, halt aggregation and the clock-enable divider.
module tb_sys_mem_arbiter;
    logic CLK;
    logic RST;

    int n_checks = 0;
    int n_errors = 0;

    sys_mem_arbiter_if #(.NREQ(2)) b0 ();
    sys_mem_arbiter_if #(.NREQ(4)) b1 ();
    sys_mem_arbiter_if #(.NREQ(2)) b2 ();

    sys_mem_arbiter #(.NREQ(2), .CLKDIV(2)) dut0 (.CLK(CLK), .RST(RST), .bus(b0));
    sys_mem_arbiter #(.NREQ(4), .CLKDIV(5)) dut1 (.CLK(CLK), .RST(RST), .bus(b1));
    sys_mem_arbiter #(.NREQ(2), .CLKDIV(1)) dut2 (.CLK(CLK), .RST(RST), .bus(b2));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  ren;
        logic [1:0]  wen;
        logic        rdy;
        logic        tbc;
        logic        tbr;
        logic        tbw;
        logic        e_ren;
        logic        e_wen;
        logic [1:0]  e_wait;
        logic        e_gid;
        logic        e_own;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reset just released: enable low now, then alternating after each edge
    task automatic div2_pattern(input string tag);
        check($sformatf("%s_div0", tag), 64'(b0.cpuclk_en), 64'(1'b0));
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("%s_div%0d", tag, k), 64'(b0.cpuclk_en), 64'(k % 2));
        end
    endtask

    initial begin
        int order[4];
        int last_p;
        int pcnt;

        order = '{2, 0, 3, 1};

        vecs = '{
            //  ren    wen    rdy   tbc   tbr   tbw   eren  ewen  ewait  egid  eown  eaddr
            '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 32'h000},
            '{2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h040},
            '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 32'h000},
            '{2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 32'h200},
            '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 32'h000},
            '{2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h040},
            '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 32'h000},
            '{2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 32'h200},
            '{2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 32'h200},
            '{2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 32'h300},
            '{2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 32'h300},
            '{2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 32'h300},
            '{2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 32'h000},
            '{2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h040},
            '{2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 32'h000},
            '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 32'h200},
            '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 32'h000},
            '{2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 32'h200},
            '{2'b11, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 32'h000},
            '{2'b11, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h040},
            '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h000}
        };

        RST = 1'b1;
        b0.req_ren = '0;  b0.req_wen = '0;
        b0.req_addr  = {32'h0000_0200, 32'h0000_0040};
        b0.req_store = {32'h1111_1111, 32'hDEAD_BEEF};
        b0.tb_ctrl = 1'b0; b0.tb_ren = 1'b0; b0.tb_wen = 1'b0;
        b0.tb_addr = 32'h300; b0.tb_store = 32'h2222_2222;
        b0.ram_load = '0; b0.ram_ready = 1'b0; b0.cpu_halt = '0;

        b1.req_ren = '0; b1.req_wen = '0; b1.req_addr = '0; b1.req_store = '0;
        b1.tb_ctrl = 1'b0; b1.tb_ren = 1'b0; b1.tb_wen = 1'b0;
        b1.tb_addr = '0; b1.tb_store = '0;
        b1.ram_load = '0; b1.ram_ready = 1'b0; b1.cpu_halt = '0;

        b2.req_ren = '0; b2.req_wen = '0; b2.req_addr = '0; b2.req_store = '0;
        b2.tb_ctrl = 1'b0; b2.tb_ren = 1'b0; b2.tb_wen = 1'b0;
        b2.tb_addr = '0; b2.tb_store = '0;
        b2.ram_load = '0; b2.ram_ready = 1'b0; b2.cpu_halt = '0;

        repeat (2) step();
        check("rst_ram_en", 64'({b0.ram_ren, b0.ram_wen}), 64'(2'b00));
        check("rst_tb_owns", 64'(b0.tb_owns), 64'(1'b0));
        check("rst_grant", 64'(b0.grant_id), 64'(1'b0));
        check("rst_halt", 64'(b0.halt), 64'(1'b0));
        check("rst_cpuclk_en", 64'(b0.cpuclk_en), 64'(1'b0));
        check("rst_addr_store", {b0.ram_addr, b0.ram_store}, 64'h0);
        check("rst_div1_en", 64'(b2.cpuclk_en), 64'(1'b1));

        RST = 1'b0;
        div2_pattern("rel");

        for (int i = 0; i < 21; i++) begin
            step();
            b0.req_ren   = vecs[i].ren;
            b0.req_wen   = vecs[i].wen;
            b0.ram_ready = vecs[i].rdy;
            b0.tb_ctrl   = vecs[i].tbc;
            b0.tb_ren    = vecs[i].tbr;
            b0.tb_wen    = vecs[i].tbw;
            #1;
            check($sformatf("vec%0d", i),
                  64'({b0.ram_ren, b0.ram_wen, b0.req_wait, b0.grant_id, b0.tb_owns, b0.ram_addr}),
                  64'({vecs[i].e_ren, vecs[i].e_wen, vecs[i].e_wait, vecs[i].e_gid,
                       vecs[i].e_own, vecs[i].e_addr}));
        end

        // Requester 0 write with ready held off for three BUSY cycles
        step();
        b0.req_ren = 2'b00; b0.req_wen = 2'b01; b0.ram_ready = 1'b0;
        b0.ram_load = 32'hCAFE_0001;
        #1;
        check("wr_idle", 64'({b0.ram_wen, b0.req_wait}), 64'({1'b0, 2'b01}));
        check("req_load", 64'(b0.req_load), 64'(32'hCAFE_0001));
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("wr_hold%0d", k),
                  {b0.ram_wen, b0.ram_ren, b0.req_wait[0], 29'(b0.ram_addr), b0.ram_store},
                  {1'b1, 1'b0, 1'b1, 29'h40, 32'hDEAD_BEEF});
        end
        step();
        b0.ram_ready = 1'b1;
        #1;
        check("wr_ready", 64'({b0.ram_wen, b0.req_wait[0]}), 64'({1'b1, 1'b0}));
        step();
        b0.req_wen = 2'b00; b0.ram_ready = 1'b0;
        #1;
        check("wr_after", 64'({b0.ram_wen, b0.ram_addr}), 64'({1'b0, 32'h0}));

        // Asynchronous reset during an active transaction
        step();
        b0.req_ren = 2'b10;
        #1;
        step();
        check("mid_busy", 64'({b0.ram_ren, b0.grant_id}), 64'({1'b1, 1'b1}));
        #2;
        RST = 1'b1;
        #1;
        check("mid_rst", 64'({b0.ram_ren, b0.ram_wen, b0.grant_id, b0.tb_owns, b0.ram_addr}),
              64'({1'b0, 1'b0, 1'b0, 1'b0, 32'h0}));
        b0.req_ren = 2'b00;
        step();
        RST = 1'b0;
        div2_pattern("rel2");

        // Halt aggregation on the 4-core instance, pulses on 2,0,3,1
        for (int j = 0; j < 4; j++) begin
            step();
            b1.cpu_halt = 4'(1 << order[j]);
            b1.tb_ctrl  = ~b1.tb_ctrl;
            step();
            b1.cpu_halt = 4'b0000;
            check($sformatf("halt_after_core%0d", order[j]), 64'(b1.halt), 64'(j == 3));
        end
        for (int j = 0; j < 3; j++) begin
            step();
            check($sformatf("halt_sticky%0d", j), 64'(b1.halt), 64'(1'b1));
        end

        // Divide-by-5 keeps its period while tb_ctrl and cpu_halt wiggle
        last_p = -1;
        pcnt   = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            b1.tb_ctrl  = 1'(c % 2);
            b1.cpu_halt = 4'($urandom);
            #1;
            if (b1.cpuclk_en) begin
                if (last_p >= 0) begin
                    check("div5_gap", 64'(c - last_p), 64'(5));
                end
                last_p = c;
                pcnt++;
            end
        end
        check("div5_count", 64'(pcnt), 64'(4));

        for (int c = 0; c < 6; c++) begin
            step();
            check($sformatf("div1_en%0d", c), 64'(b2.cpuclk_en), 64'(1'b1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sys_mem_arbiter.md
# sys_mem_arbiter

Parametrised system-level memory front end between NREQ processor memory requesters, the testbench control port, and the single-ported RAM. It generalises the two-way testbench/processor RAM mux to N requesters, adding:
- round-robin arbitration with held grants,
- a testbench takeover that drains in-flight transactions,
- a programmable CPU clock-enable divider,
- sticky all-core halt aggregation.

## Interface
Parameters:
- NREQ, 2, number of processor memory requesters (2..8)
- AW, 32, address width
- DW, 32, data width
- CLKDIV, 2, CPU clock-enable divide ratio (1..16)
- GIDW, max(1,$clog2(NREQ)), derived grant-index width

Ports:
- One clock; reset is asynchronous and active-high.
- CLK  in  1  system clock
- RST  in  1  asynchronous active-high reset
- req_ren  in  NREQ  per-requester read request
- req_wen  in  NREQ  per-requester write request
- req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
- req_store  in  NREQ*DW  packed write data
- req_wait  out  NREQ  stall to requester i
- req_load  out  DW  read data (copy of ram_load)
- tb_ctrl  in  1  testbench requests RAM ownership
- tb_ren, tb_wen  in  1  testbench read/write enables
- tb_addr  in  AW  testbench address
- tb_store  in  DW  testbench write data
- tb_owns  out  1  testbench currently drives RAM
- ram_ren, ram_wen  out  1  RAM enables
- ram_addr  out  AW  RAM address
- ram_store  out  DW  RAM write data
- ram_load  in  DW  RAM read data
- ram_ready  in  1  one-cycle pulse: current RAM access complete
- cpu_halt  in  NREQ  per-core halt
- halt  out  1  all cores have halted
- cpuclk_en  out  1  CPU clock-enable pulse
- grant_id  out  GIDW  index of granted requester

## Operation
- FSM states: IDLE, BUSY, TB.
- IDLE:
  - If tb_ctrl, go to TB.
  - Else if any requester has ren|wen, choose the first requesting index after last_grant, wrapping modulo NREQ. Latch it into grant_id and go to BUSY.
  - RAM enables are 0 in IDLE.
- BUSY:
  - RAM ports are driven combinationally from requester grant_id.
  - If the requester drives wen and ren together, wen wins and ram_ren = 0.
  - On ram_ready: last_grant <= grant_id. Go to TB if tb_ctrl, else IDLE.
  - If the grantee drops both enables before ram_ready: abort to IDLE, ram enables low that cycle, last_grant unchanged.
  - tb_ctrl asserted mid-BUSY never preempts. The transaction completes first (drain).
- TB:
  - RAM ports are driven from tb_* with tb_owns = 1. wen-over-ren priority also applies.
  - Exit to IDLE when tb_ctrl = 0.
- req_wait[i] = (req_ren[i]|req_wen[i]) & ~(state==BUSY & grant_id==i & ram_ready). Non-requesting requesters see req_wait = 0.
- req_load = ram_load unconditionally.
- Halt: halt_seen[i] is set when cpu_halt[i] = 1 and cleared only by RST. halt = &halt_seen, registered.
- Divider: counter runs 0..CLKDIV-1 and wraps. cpuclk_en = 1 in the cycle the counter equals CLKDIV-1. For CLKDIV = 1, cpuclk_en is constant 1 after reset. The divider is free-running and independent of halt and tb_ctrl.

## Timing
- Reset values:
  - state IDLE, grant_id 0, last_grant NREQ-1 (requester 0 has first priority).
  - counter 0, cpuclk_en 0 (1 if CLKDIV = 1), halt 0, halt_seen 0.
  - ram_ren/ram_wen 0, tb_owns 0.
  - ram_addr/ram_store are 0 when not in BUSY/TB.
- Arbitration latency: request at cycle t seen in IDLE gives grant at edge t+1. RAM enables are asserted in cycle t+1. With ram_ready in the same cycle, req_wait drops in t+1.
- Minimum per-transaction occupancy: 2 cycles (IDLE + BUSY). There is no back-to-back BUSY.
- tb_ctrl rise in IDLE gives tb_owns = 1 the next cycle. tb_ctrl rise in BUSY gives TB on the cycle after ram_ready.
- Halt rises one cycle after the last core's first cpu_halt pulse.
- RST mid-transaction: all outputs return to reset values immediately (asynchronous). The in-flight RAM access is abandoned.

## Test plan
- Reset with NREQ=2, CLKDIV=2: all outputs at reset values. After release, cpuclk_en toggles 0,1,0,1 starting in the second cycle.
- Requesters 0 and 1 both hold ren, ram_ready each BUSY cycle:
  - grants alternate 0,1,0,1
  - req_wait[1] stays 1 until its own ram_ready cycle
  - ram_addr follows grant_id.
- Requester 0 writing addr 0x40 data 0xDEADBEEF with ram_ready delayed 3 cycles: ram_wen held 3 BUSY cycles, req_wait[0] = 1 throughout, then 0 on ready.
- tb_ctrl raised while requester 1 is in BUSY: transaction completes, then tb_owns = 1 and tb_addr drives ram_addr. Requester 0 is stalled until tb_ctrl falls, then granted next.
- NREQ=4: cpu_halt pulses on cores 2, 0, 3, 1 at separate cycles. halt stays 0 until one cycle after core 1's pulse, then stays 1.
- CLKDIV=1: cpuclk_en = 1 every cycle. CLKDIV=5: cpuclk_en pulses every 5th cycle, unaffected by tb_ctrl or halt.
